// File: rtl/seg7_to_bcd_capture.sv
// Recovers the digit shown on an active-low 7-segment bus after the pattern has been stable,
// and reports each newly settled digit once over a valid/ready handshake. Hex decode: SEG7_HEX_EN.
module seg7_to_bcd_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic       out_ready,
  input  logic       clr_ovf,
  output logic       out_valid,
  output logic [3:0] out_value,
  output logic       out_err,
  output logic       ovf
);

  localparam logic [6:0] BLANK  = 7'b1111111;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0] seg_q;
  logic [6:0] cand_q, cand_d;
  logic [6:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       settle_q, settle_d;
  logic       valid_q, valid_d;
  logic [3:0] value_q, value_d;
  logic       err_q, err_d;
  logic       ovf_q, ovf_d;
  logic       changed;
  logic       emit;
  logic       drop;
  logic [4:0] dec;

  // Returns {err, value}; unknown patterns decode to err=1, value=0.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
`ifdef SEG7_HEX_EN
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
`endif
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  // The settle pulse is registered so the candidate it refers to is already in cand_q.
  always_comb begin
    changed  = (seg_q != cand_q);
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    if (changed) begin
      cand_d = seg_q;
      cnt_d  = 8'd1;
    end else if (cnt_q != STABLE) begin
      cnt_d = cnt_q + 8'd1;
    end
    settle_d = (cnt_d == STABLE) && (changed || (cnt_q != STABLE));
  end

  always_comb begin
    dec     = seg_decode(cand_q);
    emit    = settle_q && (cand_q != last_q) && (cand_q != BLANK);
    drop    = emit && valid_q && !out_ready;
    last_d  = settle_q ? cand_q : last_q;
    valid_d = valid_q;
    value_d = value_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    if (emit && !drop) begin
      valid_d = 1'b1;
      value_d = dec[3:0];
      err_d   = dec[4];
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= BLANK;
      cand_q   <= BLANK;
      last_q   <= BLANK;
      cnt_q    <= 8'd0;
      settle_q <= 1'b0;
      valid_q  <= 1'b0;
      value_q  <= 4'd0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      seg_q    <= seg;
      cand_q   <= cand_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      valid_q  <= valid_d;
      value_q  <= value_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_value = value_q;
  assign out_err   = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// Bench for seg7_to_bcd_capture: run-length reference model checked every cycle plus directed literal checks.
module tb_seg7_to_bcd_capture;

  localparam int S = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = BLANK;
  logic       out_ready = 1'b1;
  logic       clr_ovf = 1'b0;
  logic       out_valid;
  logic [3:0] out_value;
  logic       out_err;
  logic       ovf;

  seg7_to_bcd_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg(seg), .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_value(out_value), .out_err(out_err), .ovf(ovf));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw run length of sampled patterns; a run reaching S samples
  // becomes an event that takes effect two edges later.
  logic       armed = 1'b0;
  logic [6:0] m_prev;
  int         m_run;
  logic       ev1v, ev2v;
  logic [6:0] ev1p, ev2p;
  logic [6:0] m_last;
  logic       m_valid, m_err, m_ovf;
  logic [3:0] m_value;
  logic [4:0] acc_q[$];

  function automatic logic [4:0] model_decode(input logic [6:0] p);
    int lim = 10;
`ifdef SEG7_HEX_EN
    lim = 16;
`endif
    for (int i = 0; i < lim; i++)
      if (PAT[i] == p) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  function automatic logic [4:0] acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return 5'h1F;
  endfunction

  always @(posedge clk) begin
    logic       emit, drop;
    logic [4:0] d;
    if (rst) begin
      armed = 1'b1;
      m_prev = BLANK; m_run = 1;
      ev1v = 1'b0; ev2v = 1'b0; ev1p = BLANK; ev2p = BLANK;
      m_last = BLANK;
      m_valid = 1'b0; m_value = 4'd0; m_err = 1'b0; m_ovf = 1'b0;
    end else if (armed) begin
      emit = 1'b0;
      d = 5'h0;
      if (ev2v && ev2p != m_last) begin
        m_last = ev2p;
        if (ev2p != BLANK) begin
          emit = 1'b1;
          d = model_decode(ev2p);
        end
      end
      drop = emit && m_valid && !out_ready;
      if (m_valid && out_ready) acc_q.push_back({m_err, m_value});
      if (emit && !drop) begin
        m_valid = 1'b1; m_err = d[4]; m_value = d[3:0];
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      ev2v = ev1v; ev2p = ev1p;
      if (seg == m_prev) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1;
      end
      m_prev = seg;
      ev1v = (m_run == S);
      ev1p = seg;
    end
  end

  always @(posedge clk) begin
    #1;
    if (armed) begin
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_out_value", 32'(out_value), 32'(m_value));
      chk("cyc_out_err", 32'(out_err), 32'(m_err));
      chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic hold(input logic [6:0] p, input int n);
    seg = p;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [4:0] hex_a_exp;
`ifdef SEG7_HEX_EN
    hex_a_exp = 5'h0A;
`else
    hex_a_exp = 5'h10;
`endif
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_value", 32'(out_value), 0);
    chk("rst_err", 32'(out_err), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // single digit: exact latency, one-cycle pulse
    acc_q.delete();
    hold(PAT[3], 5);
    chk("t1_before_latency", 32'(out_valid), 0);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_value", 32'(out_value), 3);
    chk("t1_err", 32'(out_err), 0);
    @(negedge clk);
    chk("t1_pulse_end", 32'(out_valid), 0);
    repeat (10) @(negedge clk);
    chk("t1_count", acc_q.size(), 1);
    chk("t1_acc0", 32'(acc_at(0)), 3);

    // short pattern ignored; blank separates repeated digit
    acc_q.delete();
    hold(PAT[1], 3);
    hold(PAT[2], 10);
    hold(BLANK, 6);
    hold(PAT[2], 10);
    chk("t23_count", acc_q.size(), 2);
    chk("t23_acc0", 32'(acc_at(0)), 2);
    chk("t23_acc1", 32'(acc_at(1)), 2);

    // backpressure and overflow
    acc_q.delete();
    out_ready = 1'b0;
    hold(PAT[0], 8);
    chk("t4_pend_valid", 32'(out_valid), 1);
    chk("t4_pend_value", 32'(out_value), 0);
    chk("t4_no_ovf", 32'(ovf), 0);
    hold(PAT[5], 8);
    chk("t4_ovf_set", 32'(ovf), 1);
    chk("t4_kept_value", 32'(out_value), 0);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(ovf), 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_drained", 32'(out_valid), 0);

    // emission coincident with acceptance: new data loads, no overflow
    out_ready = 1'b0;
    hold(PAT[7], 8);
    hold(PAT[8], 5);
    out_ready = 1'b1;
    @(negedge clk);
    chk("tb_load_valid", 32'(out_valid), 1);
    chk("tb_load_value", 32'(out_value), 8);
    chk("tb_load_ovf", 32'(ovf), 0);
    @(negedge clk);
    chk("tb_load_drained", 32'(out_valid), 0);
    chk("tb_acc_count", acc_q.size(), 3);
    chk("tb_acc1", 32'(acc_at(1)), 7);
    chk("tb_acc2", 32'(acc_at(2)), 8);

    // overflow set and clear on the same cycle: set wins
    out_ready = 1'b0;
    hold(PAT[6], 8);
    hold(PAT[9], 5);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("tw_ovf_set_wins", 32'(ovf), 1);
    chk("tw_kept_value", 32'(out_value), 6);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // hex pattern A
    acc_q.delete();
    hold(PAT[10], 10);
    chk("t5_count", acc_q.size(), 1);
    chk("t5_hex_a", 32'(acc_at(0)), 32'(hex_a_exp));

    // reset with pending event and a pattern mid-filter
    out_ready = 1'b0;
    hold(PAT[9], 8);
    chk("t6_pend_value", 32'(out_value), 9);
    hold(PAT[4], 2);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_value", 32'(out_value), 0);
    chk("t6_rst_err", 32'(out_err), 0);
    chk("t6_rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    acc_q.delete();
    out_ready = 1'b1;
    hold(PAT[9], 10);
    chk("t6_count", acc_q.size(), 1);
    chk("t6_reported_again", 32'(acc_at(0)), 9);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
